// File: rtl/bram_be_arbiter_pkg.sv
// Shared types and constants for the two-port byte-enable BRAM arbiter.
// Optional feature macro used by this block: BRAM_ARB_RR_EN.

package bram_arb_pkg;

  // Number of requesters sharing the RAM.
  localparam int NUM_PORTS = 32'd2;

  // Requester identity; also the encoding of the last-grant pointer.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

  // The port that is not p; the preferred winner when p was granted last.
  function automatic port_id_t other_port(input port_id_t p);
    port_id_t o;
    case (p)
      PORT_A:  o = PORT_B;
      PORT_B:  o = PORT_A;
      default: o = PORT_A;
    endcase
    return o;
  endfunction

endpackage : bram_arb_pkg

// File: rtl/bram_be_arbiter_if.sv
// One requester channel of the BRAM arbiter: a valid/ready request path
// (read or byte-enabled write) and a valid/ready read-response path.
// The client side uses the master modport, the arbiter the slave modport.

interface bram_be_arbiter_if #(
  parameter int ADDR_WIDTH = 32'd10,
  parameter int DATA_WIDTH = 32'd32
);

  localparam int BE_WIDTH = DATA_WIDTH / 32'd8;

  // Request channel
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic [BE_WIDTH-1:0]   req_be;

  // Read-response channel
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_we, req_addr, req_data, req_be, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_data, req_be, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface : bram_be_arbiter_if

// File: rtl/bram_be_arbiter_pick.sv
// Two-input grant selection for the BRAM arbiter.
// With BRAM_ARB_RR_EN defined, contention is resolved round-robin using a
// last-grant pointer that resets to port B (so A wins the first contest).
// Without it, port A always wins and no pointer register exists.
// Inputs are already qualified with request-valid, so any grant is a fire.

module bram_arb_pick
  import bram_arb_pkg::*;
(
`ifdef BRAM_ARB_RR_EN
  input  logic clk,
  input  logic rst_n,
`endif
  input  logic elig_a,
  input  logic elig_b,
  output logic grant_a,
  output logic grant_b
);

`ifdef BRAM_ARB_RR_EN

  port_id_t last_r;
  port_id_t pref_s;

  // Round-robin choice: an uncontested port wins outright, otherwise the
  // port that was not granted last.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    pref_s  = other_port(last_r);
    if (elig_a && elig_b) begin
      if (pref_s == PORT_A) begin
        grant_a = 1'b1;
      end else begin
        grant_b = 1'b1;
      end
    end else begin
      grant_a = elig_a;
      grant_b = elig_b;
    end
  end

  // Last-grant pointer; it only moves when a request actually fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= PORT_B;
    end else if (grant_a) begin
      last_r <= PORT_A;
    end else if (grant_b) begin
      last_r <= PORT_B;
    end else begin
      last_r <= last_r;
    end
  end

`else

  // Fixed priority: A whenever eligible, B only when A is not.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (elig_a) begin
      grant_a = 1'b1;
    end else begin
      grant_b = elig_b;
    end
  end

`endif

endmodule : bram_arb_pick

// File: rtl/bram_be_arbiter.sv
// Shares one single-port byte-enable block RAM between two requesters.
// - One RAM operation per cycle; RAM pins are a combinational mux of the
//   granted request.
// - Each port may have at most one read outstanding; a read's data is
//   captured from ram_do one cycle after the fire and presented on the
//   port's response channel from the following cycle.
// Optional feature: define BRAM_ARB_RR_EN for round-robin arbitration;
// the default build uses fixed priority with port A first.

module bram_be_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32'd10,
  parameter int DATA_WIDTH = 32'd32,
  parameter int BE_WIDTH   = DATA_WIDTH / 32'd8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  bram_be_arbiter_if.slave      a,
  bram_be_arbiter_if.slave      b,
  output logic [DATA_WIDTH-1:0] ram_di,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [BE_WIDTH-1:0]   ram_be,
  output logic                  ram_we,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_do
);

  // A request as seen by the RAM-pin mux.
  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_WIDTH-1:0]   be;
  } req_t;

  req_t     req_a_s;
  req_t     req_b_s;
  req_t     sel_req_s;

  logic     elig_a_s;
  logic     elig_b_s;
  logic     grant_a_s;
  logic     grant_b_s;
  logic     grant_any_s;
  port_id_t grant_id_s;
  logic     rd_fire_a_s;
  logic     rd_fire_b_s;

  logic                  inflight_a_r;
  logic                  inflight_b_r;
  logic                  resp_valid_a_r;
  logic                  resp_valid_b_r;
  logic [DATA_WIDTH-1:0] resp_data_a_r;
  logic [DATA_WIDTH-1:0] resp_data_b_r;

  assign req_a_s = '{we: a.req_we, addr: a.req_addr, data: a.req_data, be: a.req_be};
  assign req_b_s = '{we: b.req_we, addr: b.req_addr, data: b.req_data, be: b.req_be};

  // Eligibility: writes whenever valid; reads only with no read in flight
  // and a response buffer that is empty or being drained this cycle.
  // Nothing is eligible while reset is asserted.
  always_comb begin
    elig_a_s = 1'b0;
    elig_b_s = 1'b0;
    if (RESET_N) begin
      elig_a_s = a.req_valid &&
                 (a.req_we || (!inflight_a_r && (!resp_valid_a_r || a.resp_ready)));
      elig_b_s = b.req_valid &&
                 (b.req_we || (!inflight_b_r && (!resp_valid_b_r || b.resp_ready)));
    end else begin
      elig_a_s = 1'b0;
      elig_b_s = 1'b0;
    end
  end

  bram_arb_pick u_pick (
`ifdef BRAM_ARB_RR_EN
    .clk     (CLK),
    .rst_n   (RESET_N),
`endif
    .elig_a  (elig_a_s),
    .elig_b  (elig_b_s),
    .grant_a (grant_a_s),
    .grant_b (grant_b_s)
  );

  assign a.req_ready = grant_a_s;
  assign b.req_ready = grant_b_s;

  // Reduce the two one-hot grants to "any grant" plus the winning port id.
  always_comb begin
    grant_any_s = grant_a_s || grant_b_s;
    grant_id_s  = PORT_A;
    if (grant_b_s) begin
      grant_id_s = PORT_B;
    end else begin
      grant_id_s = PORT_A;
    end
  end

  // Read fires per port feed the in-flight flags.
  always_comb begin
    rd_fire_a_s = grant_a_s && !req_a_s.we;
    rd_fire_b_s = grant_b_s && !req_b_s.we;
  end

  // RAM pin mux: the granted request drives the RAM; a read forces all
  // byte enables low, and with no grant the RAM sits idle.
  always_comb begin
    sel_req_s = '0;
    ram_di    = '0;
    ram_addr  = '0;
    ram_be    = '0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    case (grant_id_s)
      PORT_A:  sel_req_s = req_a_s;
      PORT_B:  sel_req_s = req_b_s;
      default: sel_req_s = '0;
    endcase
    if (grant_any_s) begin
      ram_addr = sel_req_s.addr;
      ram_di   = sel_req_s.data;
      if (sel_req_s.we) begin
        ram_we = 1'b1;
        ram_be = sel_req_s.be;
      end else begin
        ram_re = 1'b1;
        ram_be = '0;
      end
    end else begin
      ram_we = 1'b0;
      ram_re = 1'b0;
    end
  end

  // In-flight flags: set the cycle after a read fires, i.e. exactly while
  // ram_do carries that read's data. Reset drops any outstanding read.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      inflight_a_r <= 1'b0;
      inflight_b_r <= 1'b0;
    end else begin
      inflight_a_r <= rd_fire_a_s;
      inflight_b_r <= rd_fire_b_s;
    end
  end

  // Port A response buffer: capture ram_do while in flight, otherwise
  // clear on consumption; a capture wins over a same-cycle consume.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      resp_valid_a_r <= 1'b0;
      resp_data_a_r  <= '0;
    end else if (inflight_a_r) begin
      resp_valid_a_r <= 1'b1;
      resp_data_a_r  <= ram_do;
    end else if (a.resp_ready) begin
      resp_valid_a_r <= 1'b0;
      resp_data_a_r  <= resp_data_a_r;
    end else begin
      resp_valid_a_r <= resp_valid_a_r;
      resp_data_a_r  <= resp_data_a_r;
    end
  end

  // Port B response buffer: same policy as port A.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      resp_valid_b_r <= 1'b0;
      resp_data_b_r  <= '0;
    end else if (inflight_b_r) begin
      resp_valid_b_r <= 1'b1;
      resp_data_b_r  <= ram_do;
    end else if (b.resp_ready) begin
      resp_valid_b_r <= 1'b0;
      resp_data_b_r  <= resp_data_b_r;
    end else begin
      resp_valid_b_r <= resp_valid_b_r;
      resp_data_b_r  <= resp_data_b_r;
    end
  end

  assign a.resp_valid = resp_valid_a_r;
  assign a.resp_data  = resp_data_a_r;
  assign b.resp_valid = resp_valid_b_r;
  assign b.resp_data  = resp_data_b_r;

endmodule : bram_be_arbiter

// File: tb/tb_bram_be_arbiter.sv
// Directed testbench for bram_be_arbiter with a behavioural byte-enable RAM.
// Inputs change on the falling edge; outputs are sampled 1 ns later.

module tb_bram_be_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic CLK = 1'b0;
  logic RESET_N;

  always #5 CLK = ~CLK;

  bram_be_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a_if ();
  bram_be_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b_if ();

  logic [DW-1:0] ram_di;
  logic [AW-1:0] ram_addr;
  logic [BW-1:0] ram_be;
  logic          ram_we;
  logic          ram_re;
  logic [DW-1:0] ram_do;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;

  bram_be_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .a        (a_if),
    .b        (b_if),
    .ram_di   (ram_di),
    .ram_addr (ram_addr),
    .ram_be   (ram_be),
    .ram_we   (ram_we),
    .ram_re   (ram_re),
    .ram_do   (ram_do)
  );

  // Single-port byte-enable RAM: write commits at the edge, read data one cycle later.
  always @(posedge CLK) begin
    if (ram_we) begin
      for (int i = 0; i < BW; i++) begin
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_di[8*i +: 8];
      end
    end
    if (ram_re) ram_do <= mem[ram_addr];
  end

  task automatic clear_reqs();
    a_if.req_valid = 1'b0; a_if.req_we = 1'b0; a_if.req_addr = '0; a_if.req_data = '0; a_if.req_be = '0;
    b_if.req_valid = 1'b0; b_if.req_we = 1'b0; b_if.req_addr = '0; b_if.req_data = '0; b_if.req_be = '0;
  endtask

  task automatic set_a(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [BW-1:0] be);
    a_if.req_valid = 1'b1; a_if.req_we = we; a_if.req_addr = addr; a_if.req_data = data; a_if.req_be = be;
  endtask

  task automatic set_b(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [BW-1:0] be);
    b_if.req_valid = 1'b1; b_if.req_we = we; b_if.req_addr = addr; b_if.req_data = data; b_if.req_be = be;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    clear_reqs();
    a_if.resp_ready = 1'b1;
    b_if.resp_ready = 1'b1;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic idle(input int n);
    clear_reqs();
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    a_if.resp_ready = 1'b1;
    b_if.resp_ready = 1'b1;
    set_a(1'b0, 10'd1, '0, '0);
    set_b(1'b1, 10'd2, 32'h1, 4'hF);
    @(negedge CLK);
    #1;
    checks++;
    if ({a_if.req_ready, b_if.req_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready act=%b exp=00", {a_if.req_ready, b_if.req_ready});
    end
    checks++;
    if ({ram_we, ram_re} !== 2'b00) begin
      failures++; $display("FAIL reset_ram_we_re act=%b exp=00", {ram_we, ram_re});
    end
    checks++;
    if ({a_if.resp_valid, b_if.resp_valid} !== 2'b00) begin
      failures++; $display("FAIL reset_resp_valid act=%b exp=00", {a_if.resp_valid, b_if.resp_valid});
    end
    clear_reqs();
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    checks++;
    if ({a_if.resp_valid, b_if.resp_valid, ram_we, ram_re} !== 4'b0000) begin
      failures++; $display("FAIL reset_release_idle act=%b exp=0000", {a_if.resp_valid, b_if.resp_valid, ram_we, ram_re});
    end
  endtask

  task automatic test_write_read();
    @(negedge CLK);
    set_a(1'b1, 10'd5, 32'hDEADBEEF, 4'hF);
    #1;
    checks++;
    if ({a_if.req_ready, ram_we, ram_re} !== 3'b110) begin
      failures++; $display("FAIL wr_grant act=%b exp=110", {a_if.req_ready, ram_we, ram_re});
    end
    checks++;
    if ({ram_addr, ram_be, ram_di} !== {10'd5, 4'hF, 32'hDEADBEEF}) begin
      failures++; $display("FAIL wr_pins act=%h/%h/%h exp=005/f/deadbeef", ram_addr, ram_be, ram_di);
    end
    @(negedge CLK);
    a_if.req_we = 1'b0;
    #1;
    checks++;
    if ({a_if.req_ready, ram_we, ram_re, ram_be} !== 7'b101_0000) begin
      failures++; $display("FAIL rd_grant act=%b exp=1010000", {a_if.req_ready, ram_we, ram_re, ram_be});
    end
    @(negedge CLK);
    #1;
    checks++;
    if ({a_if.req_ready, a_if.resp_valid} !== 2'b00) begin
      failures++; $display("FAIL rd_inflight act=%b exp=00", {a_if.req_ready, a_if.resp_valid});
    end
    clear_reqs();
    @(negedge CLK);
    checks++;
    if ({a_if.resp_valid, a_if.resp_data} !== {1'b1, 32'hDEADBEEF}) begin
      failures++; $display("FAIL rd_resp act=%b/%h exp=1/deadbeef", a_if.resp_valid, a_if.resp_data);
    end
    @(negedge CLK);
    checks++;
    if (a_if.resp_valid !== 1'b0) begin
      failures++; $display("FAIL rd_resp_consumed act=%b exp=0", a_if.resp_valid);
    end
  endtask

  task automatic test_partial_write();
    @(negedge CLK);
    set_a(1'b1, 10'd5, 32'h11223344, 4'b0101);
    #1;
    checks++;
    if ({a_if.req_ready, ram_be} !== 5'b1_0101) begin
      failures++; $display("FAIL pw_grant act=%b exp=10101", {a_if.req_ready, ram_be});
    end
    @(negedge CLK);
    a_if.req_we = 1'b0;
    @(negedge CLK);
    clear_reqs();
    @(negedge CLK);
    checks++;
    if ({a_if.resp_valid, a_if.resp_data} !== {1'b1, 32'hDE22BE44}) begin
      failures++; $display("FAIL pw_resp act=%b/%h exp=1/de22be44", a_if.resp_valid, a_if.resp_data);
    end
    idle(2);
  endtask

  task automatic test_contention_reads();
    logic [1:0] exp_g [4];
    exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
    do_reset();
    @(negedge CLK);
    set_a(1'b0, 10'd5, '0, '0);
    set_b(1'b0, 10'd5, '0, '0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({a_if.req_ready, b_if.req_ready} !== exp_g[i]) begin
        failures++; $display("FAIL rd_contention[%0d] act=%b exp=%b", i, {a_if.req_ready, b_if.req_ready}, exp_g[i]);
      end
      @(negedge CLK);
    end
    idle(3);
  endtask

  task automatic test_contention_write_vs_read();
    logic [1:0] exp_g [4];
`ifdef BRAM_ARB_RR_EN
    exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    exp_g = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    do_reset();
    @(negedge CLK);
    set_a(1'b1, 10'd20, 32'h0A0B0C0D, 4'hF);
    set_b(1'b0, 10'd5, '0, '0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({a_if.req_ready, b_if.req_ready} !== exp_g[i]) begin
        failures++; $display("FAIL wr_rd_contention[%0d] act=%b exp=%b", i, {a_if.req_ready, b_if.req_ready}, exp_g[i]);
      end
      @(negedge CLK);
    end
    idle(3);
  endtask

  task automatic test_backpressure();
    @(negedge CLK);
    b_if.resp_ready = 1'b0;
    set_b(1'b0, 10'd5, '0, '0);
    #1;
    checks++;
    if (b_if.req_ready !== 1'b1) begin
      failures++; $display("FAIL bp_first_read act=%b exp=1", b_if.req_ready);
    end
    @(negedge CLK);
    clear_reqs();
    @(negedge CLK);
    checks++;
    if ({b_if.resp_valid, b_if.resp_data} !== {1'b1, 32'hDE22BE44}) begin
      failures++; $display("FAIL bp_resp act=%b/%h exp=1/de22be44", b_if.resp_valid, b_if.resp_data);
    end
    set_b(1'b0, 10'd20, '0, '0);
    set_a(1'b0, 10'd5, '0, '0);
    #1;
    checks++;
    if ({a_if.req_ready, b_if.req_ready} !== 2'b10) begin
      failures++; $display("FAIL bp_a_served act=%b exp=10", {a_if.req_ready, b_if.req_ready});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      checks++;
      if ({b_if.req_ready, b_if.resp_valid, b_if.resp_data} !== {2'b01, 32'hDE22BE44}) begin
        failures++; $display("FAIL bp_b_held[%0d] act=%b/%b/%h exp=0/1/de22be44", i, b_if.req_ready, b_if.resp_valid, b_if.resp_data);
      end
    end
    @(negedge CLK);
    a_if.req_valid = 1'b0;
    b_if.resp_ready = 1'b1;
    #1;
    checks++;
    if (b_if.req_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release_grant act=%b exp=1", b_if.req_ready);
    end
    @(negedge CLK);
    clear_reqs();
    checks++;
    if (b_if.resp_valid !== 1'b0) begin
      failures++; $display("FAIL bp_drained act=%b exp=0", b_if.resp_valid);
    end
    @(negedge CLK);
    checks++;
    if ({b_if.resp_valid, b_if.resp_data} !== {1'b1, 32'h0A0B0C0D}) begin
      failures++; $display("FAIL bp_next_resp act=%b/%h exp=1/0a0b0c0d", b_if.resp_valid, b_if.resp_data);
    end
    idle(3);
  endtask

  task automatic test_back_to_back_ordering();
    @(negedge CLK);
    set_a(1'b1, 10'd30, 32'hCAFEF00D, 4'hF);
    #1;
    checks++;
    if ({a_if.req_ready, ram_we, ram_re} !== 3'b110) begin
      failures++; $display("FAIL ord_write act=%b exp=110", {a_if.req_ready, ram_we, ram_re});
    end
    @(negedge CLK);
    clear_reqs();
    set_b(1'b0, 10'd30, '0, '0);
    #1;
    checks++;
    if ({b_if.req_ready, ram_we, ram_re, ram_addr} !== {3'b101, 10'd30}) begin
      failures++; $display("FAIL ord_read act=%b/%0d exp=101/30", {b_if.req_ready, ram_we, ram_re}, ram_addr);
    end
    @(negedge CLK);
    clear_reqs();
    #1;
    checks++;
    if ({ram_we, ram_re} !== 2'b00) begin
      failures++; $display("FAIL ord_idle act=%b exp=00", {ram_we, ram_re});
    end
    @(negedge CLK);
    checks++;
    if ({b_if.resp_valid, b_if.resp_data} !== {1'b1, 32'hCAFEF00D}) begin
      failures++; $display("FAIL ord_resp act=%b/%h exp=1/cafef00d", b_if.resp_valid, b_if.resp_data);
    end
    idle(3);
  endtask

  task automatic test_reset_midop();
    @(negedge CLK);
    set_a(1'b0, 10'd5, '0, '0);
    #1;
    checks++;
    if (a_if.req_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_fire act=%b exp=1", a_if.req_ready);
    end
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({a_if.req_ready, ram_we, ram_re, a_if.resp_valid} !== 4'b0000) begin
      failures++; $display("FAIL rst_mid_hold act=%b exp=0000", {a_if.req_ready, ram_we, ram_re, a_if.resp_valid});
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    clear_reqs();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (a_if.resp_valid !== 1'b0) begin
        failures++; $display("FAIL rst_mid_no_resp[%0d] act=%b exp=0", i, a_if.resp_valid);
      end
    end
    set_a(1'b0, 10'd5, '0, '0);
    set_b(1'b0, 10'd5, '0, '0);
    #1;
    checks++;
    if ({a_if.req_ready, b_if.req_ready} !== 2'b10) begin
      failures++; $display("FAIL rst_mid_first_contention act=%b exp=10", {a_if.req_ready, b_if.req_ready});
    end
    idle(3);
  endtask

  initial begin
    clear_reqs();
    test_reset();
    test_write_read();
    test_partial_write();
    test_contention_reads();
    test_contention_write_vs_read();
    test_backpressure();
    test_back_to_back_ordering();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bram_be_arbiter
